// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The BOOT_CHECKSUM_EN build macro enables the trailing XOR checksum byte.
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int HDR_W          = 8;

    // A header H is legal when N = H+1 words fit in a 2^addr_w deep memory.
    function automatic logic hdr_ok(input logic [HDR_W-1:0] h, input int addr_w);
        if (addr_w >= HDR_W) return 1'b1;
        return int'(h) <= ((1 << addr_w) - 1);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian word assembler: the first byte of a word lands in bits [7:0].
module byte_assembler
    import boot_pkg::*;
(
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shift_en,
    input  logic [7:0]                  byte_in,
    input  logic                        clear,
    output logic [8*BYTES_PER_WORD-1:0] word_out,
    output logic                        word_full
);

    logic [8*BYTES_PER_WORD-1:0] r_word;
    logic [1:0]                  r_cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (clear) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (shift_en) begin
            r_word <= {byte_in, r_word[8*BYTES_PER_WORD-1:8]};
            r_cnt  <= r_cnt + 2'd1;
        end
    end

    // High while the next accepted byte completes the word.
    assign word_full = (r_cnt == 2'(BYTES_PER_WORD - 1));
    assign word_out  = r_word;

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream program loader for the MIPS instruction memory; holds the core in
// reset until a full image is written. Build macro: BOOT_CHECKSUM_EN.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_t             r_state, w_next;
    logic [HDR_W-1:0]   r_hdr;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_in_ready, r_we, r_core_reset, r_busy, r_done, r_error;
    logic               w_xfer, w_hdr_xfer, w_data_xfer, w_last, w_full;
    logic [31:0]        w_word;

    assign w_xfer      = in_valid && r_in_ready;
    assign w_hdr_xfer  = w_xfer && (r_state == HDR);
    assign w_data_xfer = w_xfer && (r_state == DATA);
    assign w_last      = (32'(r_addr) == 32'(r_hdr));

    byte_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .shift_en (w_data_xfer),
        .byte_in  (in_data),
        .clear    (w_hdr_xfer),
        .word_out (w_word),
        .word_full(w_full)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] r_acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_acc <= '0;
        end else if (w_next == HDR && r_state != HDR) begin
            r_acc <= '0;
        end else if (w_data_xfer) begin
            r_acc <= r_acc ^ in_data;
        end
    end
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: if (start) w_next = HDR;
            HDR:   if (w_xfer) w_next = hdr_ok(in_data, ADDR_W) ? DATA : ERR;
            DATA:  if (w_xfer && w_full) w_next = WRITE;
`ifdef BOOT_CHECKSUM_EN
            WRITE: w_next = w_last ? CHK : DATA;
            CHK:   if (w_xfer) w_next = (in_data == r_acc) ? DONE : ERR;
`else
            WRITE: w_next = w_last ? DONE : DATA;
`endif
            default: w_next = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_hdr        <= '0;
            r_addr       <= '0;
            r_in_ready   <= 1'b0;
            r_we         <= 1'b0;
            r_core_reset <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_hdr_xfer) begin
                r_hdr  <= in_data;
                r_addr <= '0;
            end else if (r_state == WRITE) begin
                r_addr <= r_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
            r_in_ready   <= (w_next == HDR) || (w_next == DATA) || (w_next == CHK);
            r_we         <= (w_next == WRITE);
            r_core_reset <= (w_next != DONE);
            r_busy       <= (w_next == HDR) || (w_next == DATA) ||
                            (w_next == WRITE) || (w_next == CHK);
            r_done       <= (w_next == DONE);
            r_error      <= (w_next == ERR);
        end
    end

    assign in_ready   = r_in_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = w_word;
    assign core_reset = r_core_reset;
    assign busy       = r_busy;
    assign done       = r_done;
    assign error      = r_error;

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Program loader sitting directly upstream of the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word is written into the core's instruction memory. The core is held in reset until a complete, well-formed image has been written, after which the core is released to fetch from PC 0.

## Interface
Parameters:
- ADDR_W, 5, instruction-memory word-address width; depth = 2^ADDR_W words

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low; loader state is cleared on a clk edge with reset==0
- start  input  1  one-cycle pulse, begins a load from IDLE, DONE or ERR
- in_valid  input  1  byte available on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader can accept a byte this cycle
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address of write
- imem_wdata  output  32  instruction word
- core_reset  output  1  active-high reset to the MIPS core
- busy  output  1  load in progress
- done  output  1  image loaded, core running
- error  output  1  malformed image

## Operation
- Stream format:
  - Header byte H; word count is N = H+1.
  - Followed by 4N payload bytes, byte 0 of each word = bits [7:0].
  - With BOOT_CHECKSUM_EN, the payload is followed by one checksum byte.
- A byte transfers on a clk edge with in_valid && in_ready. in_valid may stall arbitrarily; the loader never drops or duplicates bytes.
- States:
  - IDLE: core_reset=1, in_ready=0. On start, go to HDR.
  - HDR: in_ready=1. On transfer, H is latched. If H > 2^ADDR_W-1, go to ERR. Otherwise go to DATA, with the word address cleared to 0.
  - DATA: in_ready=1. Bytes are shifted into the word register, and a 2-bit byte counter increments. On the 4th byte, go to WRITE.
  - WRITE: in_ready=0, imem_we=1 with the current addr and word. The address then increments. If the written word was word N-1, go to CHK when checksum is enabled, else DONE. Otherwise return to DATA.
  - CHK: in_ready=1. On transfer, compare the byte with the XOR of all payload bytes. A match goes to DONE; a mismatch goes to ERR.
  - DONE: core_reset=0, done=1. On start, go to HDR; core_reset is reasserted the same cycle as the start.
  - ERR: core_reset=1, error=1. On start, go to HDR.
- busy=1 in HDR/DATA/WRITE/CHK.
- A start pulse while busy is ignored.
- The address counter is ADDR_W bits and never wraps in a legal image, because the header check bounds N ≤ 2^ADDR_W.
- For ADDR_W ≥ 8, every header value is legal.

## Timing
- All outputs are registered.
- Reset values: in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=1, busy=0, done=0, error=0. The state is IDLE and the checksum accumulator is 0.
- Minimum load time is 1 + 5N (+1 with checksum) cycles after start, with in_valid held high.
- imem_we is high for exactly one cycle per word. imem_addr/imem_wdata are stable during that cycle.
- done/core_reset change on the cycle after the last WRITE (or CHK) transfer cycle.
- Reset asserted mid-load aborts the load: the next cycle shows reset values. Partially written imem contents are not cleared.
- start on the same edge as a byte transfer in HDR/DATA/CHK is ignored; the transfer proceeds.

## Configuration
- BOOT_CHECKSUM_EN defined:
  - CHK state and the XOR accumulator are compiled in.
  - The accumulator is cleared on entry to HDR.
  - The trailing checksum byte is mandatory.
- BOOT_CHECKSUM_EN undefined:
  - No CHK state and no accumulator; the stream ends after the last payload byte.
  - error is asserted only for an oversized header.

## Structure
- Package boot_pkg:
  - state enum (IDLE, HDR, DATA, WRITE, CHK, DONE, ERR)
  - BYTES_PER_WORD = 4
  - HDR_W = 8
- Sub-module byte_assembler:
  - Contains the 32-bit little-endian shift register and the 2-bit byte counter.
  - Ports: clk, reset, shift_en, byte_in, clear, word_out, word_full.
- Top-level FSM, address counter and checksum live in imem_boot_loader.

## Test plan
- Load an 11-word program: H=0x0A, first word bytes 0A 00 08 20, in_valid held high.
  - Expected: imem_we at addr 0 with 0x2008000A.
  - 11 writes at addr 0..10.
  - done=1 and core_reset=0 at cycle 56 after start.
- Same image with in_valid toggled every other cycle: identical write sequence and data; load time stretched, no lost bytes.
- ADDR_W=5, H=0x20: ERR after the header, error=1, core_reset=1, no imem_we pulses.
- With BOOT_CHECKSUM_EN:
  - 1-word image bytes 78 56 34 12, checksum 0x08 → done=1.
  - Same image with checksum 0x09 → error=1, core_reset=1.
- Reset driven low after 2 of 4 words: outputs return to reset values the next cycle. A new start plus a full image then loads correctly from addr 0.
- start pulsed in DONE: core_reset=1 the same cycle, done=0, busy=1; the reload completes normally.
